des_ahb_master: RTL

DES_AHB_MASTER -- requirements
Module: des_ahb_master

---
 rtl/des_ahb_master.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/des_ahb_master.sv
// des_ahb_master: single-outstanding AHB-Lite master that turns a valid/ready
// command into one NONSEQ SINGLE word transfer and returns a one-cycle response.
// Optional feature macro DES_AHB_MST_TIMEOUT_EN: aborts a transfer after
// TIMEOUT_CYCLES consecutive hready_resp-low cycles with rsp_err=1.
module des_ahb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [9:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        hsel,
    output logic [9:0]  haddr,
    output logic        hwrite,
    output logic [1:0]  htrans,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [31:0] hwdata,
    output logic        hready,
    input  logic        hready_resp,
    input  logic [1:0]  hresp,
    input  logic [31:0] hrdata
);

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t          state, state_next;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            cmd_ready_d, hsel_d, hwrite_d, rsp_valid_d, rsp_err_d;
    logic [1:0]      htrans_d;
    logic [AW-1:0]   haddr_d;
    logic [DW-1:0]   hwdata_d, rsp_rdata_d;
    logic            busy_c;
    logic            timeout_c;

    // A zero timeout would never let a transfer start its wait count.
    if (TIMEOUT_CYCLES == 0) begin : g_cfg_check
        $error("des_ahb_master: TIMEOUT_CYCLES must be at least 1");
    end

    assign hsize  = 3'b010;
    assign hburst = 3'b000;
    assign hready = hready_resp;
    assign busy_c = (state == S_ADDR) || (state == S_DATA);

`ifdef DES_AHB_MST_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Count consecutive stalled cycles; any progress or state change clears it.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            tmo_cnt <= '0;
        end else if (busy_c && !hready_resp && !timeout_c) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign timeout_c = busy_c && !hready_resp
                       && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // Next state and next value of every registered output.
    always_comb begin
        state_next  = state;
        cmd_ready_d = 1'b0;
        hsel_d      = 1'b0;
        htrans_d    = HTRANS_IDLE;
        haddr_d     = haddr;
        hwrite_d    = hwrite;
        hwdata_d    = hwdata;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_next = S_ADDR;
                    haddr_d    = cmd_addr;
                    hwrite_d   = cmd_write;
                    wdata_d    = cmd_wdata;
                    hsel_d     = 1'b1;
                    htrans_d   = HTRANS_NONSEQ;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            S_ADDR: begin
                if (timeout_c) begin
                    state_next  = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (hready_resp) begin
                    state_next = S_DATA;
                    hsel_d     = 1'b1;
                    if (hwrite) begin
                        hwdata_d = wdata_q;
                    end
                end else begin
                    hsel_d   = 1'b1;
                    htrans_d = HTRANS_NONSEQ;
                end
            end
            S_DATA: begin
                if (timeout_c) begin
                    state_next  = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (hready_resp) begin
                    state_next  = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (hresp != HRESP_OKAY);
                    if (!hwrite && (hresp == HRESP_OKAY)) begin
                        rsp_rdata_d = hrdata;
                    end
                end else begin
                    hsel_d = 1'b1;
                end
            end
            S_RESP: begin
                state_next  = S_IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b0;
            hsel      <= 1'b0;
            htrans    <= HTRANS_IDLE;
            haddr     <= '0;
            hwrite    <= 1'b0;
            hwdata    <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_next;
            cmd_ready <= cmd_ready_d;
            hsel      <= hsel_d;
            htrans    <= htrans_d;
            haddr     <= haddr_d;
            hwrite    <= hwrite_d;
            hwdata    <= hwdata_d;
            wdata_q   <= wdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
        end
    end

endmodule
